s_rca_accumulator: RTL

// - Sequential consumer of the signed ripple-carry adder output: sums a framed stream of

---
 rtl/s_rca_accumulator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/s_rca_accumulator.sv
// Framed signed accumulator: sums a stream of signed operands through a ripple-carry
// adder and emits one result per frame. Optional ACC_SATURATE_EN clamps on overflow.
module s_rca_accumulator #(
  parameter int WIDTH   = 32,
  parameter int ACC_W   = 40,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // valid never depends on ready; in_ready drops while a result waits in HOLD.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_W-1:0]     out_sum_q, out_sum_d;
  logic [COUNT_W-1:0]   out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [ACC_W:0]       a_ext, b_ext, nsum;
  logic                 carry;
  logic                 ovf_now;
  logic [ACC_W-1:0]     acc_next;
  logic [COUNT_W-1:0]   cnt_inc;
  logic                 accept;
  logic                 close;

  assign in_ready = (state_q != HOLD) && rst_n;
  assign accept   = in_valid && in_ready;

  assign a_ext = {acc_q[ACC_W-1], acc_q};
  assign b_ext = {{(ACC_W + 1 - WIDTH){in_data[WIDTH-1]}}, in_data};

  always_comb begin
    carry = 1'b0;
    nsum  = '0;
    for (int i = 0; i <= ACC_W; i++) begin
      nsum[i] = a_ext[i] ^ b_ext[i] ^ carry;
      carry   = (a_ext[i] & b_ext[i]) | (carry & (a_ext[i] ^ b_ext[i]));
    end
  end

  // The extra top bit disagrees with the ACC_W-bit sign only on signed overflow.
  assign ovf_now = nsum[ACC_W] ^ nsum[ACC_W-1];

`ifdef ACC_SATURATE_EN
  always_comb begin
    if (!ovf_now) begin
      acc_next = nsum[ACC_W-1:0];
    end else if (nsum[ACC_W]) begin
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = nsum[ACC_W-1:0];
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign close   = in_last || (cnt_inc == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (close) begin
            out_sum_d   = acc_next;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | ovf_now;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d   = acc_next;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_q | ovf_now;
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
